// File: rtl/march_bist_pkg.sv
// Shared definitions for the March BIST controller: FSM states, algorithm
// selects and the element tables for MATS+ and March C-.
package march_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_FLUSH = 3'd2,
        ST_DONE  = 3'd3,
        ST_HOLD  = 3'd4
    } state_e;

    localparam logic ALGO_MATS    = 1'b0;
    localparam logic ALGO_MARCH_CM = 1'b1;

    // Per-element op-code: one or two ops per address, each a read or write of
    // background polarity pol (0 = bg0, 1 = ~bg0), swept up or down.
    typedef struct packed {
        logic two_ops;
        logic rd0;
        logic pol0;
        logic rd1;
        logic pol1;
        logic down;
    } elem_t;

    localparam elem_t EL_W0_UP   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam elem_t EL_R0W1_UP = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    localparam elem_t EL_R1W0_UP = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam elem_t EL_R0W1_DN = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam elem_t EL_R1W0_DN = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    localparam elem_t EL_R0_UP   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    localparam elem_t [2:0] MATS_TBL = {EL_R1W0_DN, EL_R0W1_UP, EL_W0_UP};
    localparam elem_t [5:0] MARCH_CM_TBL = {EL_R0_UP, EL_R1W0_DN, EL_R0W1_DN,
                                            EL_R1W0_UP, EL_R0W1_UP, EL_W0_UP};

    function automatic logic [2:0] last_elem(input logic algo);
        return (algo == ALGO_MARCH_CM) ? 3'd5 : 3'd2;
    endfunction

    function automatic elem_t elem_lookup(input logic algo, input logic [2:0] idx);
        elem_t e;
        e = EL_W0_UP;
        if (algo == ALGO_MARCH_CM) begin
            if (idx <= 3'd5) e = MARCH_CM_TBL[idx];
        end else begin
            if (idx <= 3'd2) e = MATS_TBL[idx[1:0]];
        end
        return e;
    endfunction

endpackage

// File: rtl/march_bist_addr_gen.sv
// Up/down address sweep counter with load, step and end-of-sweep flag.
module march_bist_addr_gen #(
    parameter int AWIDTH = 4,
    parameter int DEPTH  = 2**AWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              load_down_i,
    input  logic              step_i,
    input  logic              down_i,
    output logic [AWIDTH-1:0] addr_o,
    output logic              last_o
);

    localparam logic [AWIDTH-1:0] TOP = AWIDTH'(DEPTH - 1);

    logic [AWIDTH-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load_i)
            addr_d = load_down_i ? TOP : '0;
        else if (step_i)
            addr_d = down_i ? addr_q - AWIDTH'(1) : addr_q + AWIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst) addr_q <= '0;
        else      addr_q <= addr_d;
    end

    assign addr_o = addr_q;
    assign last_o = down_i ? (addr_q == '0) : (addr_q == TOP);

endmodule

// File: rtl/march_bist_controller.sv
// March BIST controller (MATS+ / March C-, solid or checkerboard background).
// Define MARCH_BIST_FAIL_LOG_EN to log the first failing address and a fail count.
module march_bist_controller
    import march_bist_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 4,
    parameter int DEPTH  = 2**AWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Test,
    input  logic              algo_sel,
    input  logic              bg_sel,
    output logic              we,
    output logic [AWIDTH-1:0] wraddr,
    output logic [DWIDTH-1:0] datain,
    output logic              re,
    output logic [AWIDTH-1:0] rdaddr,
    input  logic [DWIDTH-1:0] rddata,
    output logic              bist_busy,
    output logic              bist_status,
    output logic              bist_check_valid,
    output logic [AWIDTH-1:0] fail_addr,
    output logic [7:0]        fail_count
);

    localparam logic [DWIDTH-1:0] CHECKER = {(DWIDTH/2){2'b01}};

    state_e            state_q, state_d;
    logic              test_q, algo_q, bg_q, op_q;
    logic [2:0]        elem_q;
    logic              busy_q, status_q, cv_q;
    logic              cmp_vld_q;
    logic [DWIDTH-1:0] exp_q;

    elem_t             cur;
    logic              cur_rd, cur_pol, run, start, op_last, elem_end, last_op_run;
    logic              mismatch;
    logic [DWIDTH-1:0] bg0, wdata;
    logic [AWIDTH-1:0] addr;
    logic              addr_last;

    assign cur     = elem_lookup(algo_q, elem_q);
    assign cur_rd  = op_q ? cur.rd1  : cur.rd0;
    assign cur_pol = op_q ? cur.pol1 : cur.pol0;
    assign bg0     = bg_q ? CHECKER : '0;
    assign wdata   = cur_pol ? ~bg0 : bg0;

    assign run         = (state_q == ST_RUN);
    assign start       = (state_q == ST_IDLE) && Test && !test_q;
    assign op_last     = !cur.two_ops || op_q;
    assign elem_end    = run && op_last && addr_last;
    assign last_op_run = elem_end && (elem_q == last_elem(algo_q));
    assign mismatch    = cmp_vld_q && (rddata != exp_q);

    // Element 0 always sweeps ascending, so a start loads address 0.
    march_bist_addr_gen #(.AWIDTH(AWIDTH), .DEPTH(DEPTH)) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .load_i      (start || (elem_end && !last_op_run)),
        .load_down_i (start ? 1'b0 : elem_lookup(algo_q, 3'(elem_q + 3'd1)).down),
        .step_i      (run && op_last && !addr_last),
        .down_i      (cur.down),
        .addr_o      (addr),
        .last_o      (addr_last)
    );

    assign we     = run && !cur_rd;
    assign re     = run && cur_rd;
    assign wraddr = we ? addr  : '0;
    assign datain = we ? wdata : '0;
    assign rdaddr = re ? addr  : '0;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN:   if (!Test) state_d = ST_IDLE;
                      else if (last_op_run) state_d = ST_FLUSH;
            ST_FLUSH: state_d = Test ? ST_DONE : ST_IDLE;
            ST_DONE:  state_d = ST_HOLD;
            ST_HOLD:  if (!Test) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            test_q    <= 1'b0;
            algo_q    <= ALGO_MATS;
            bg_q      <= 1'b0;
            elem_q    <= '0;
            op_q      <= 1'b0;
            busy_q    <= 1'b0;
            status_q  <= 1'b0;
            cv_q      <= 1'b0;
            cmp_vld_q <= 1'b0;
            exp_q     <= '0;
        end else begin
            state_q   <= state_d;
            test_q    <= Test;
            cv_q      <= (state_q == ST_DONE);
            cmp_vld_q <= run && Test && cur_rd;
            exp_q     <= wdata;
            if (start) begin
                algo_q   <= algo_sel;
                bg_q     <= bg_sel;
                elem_q   <= '0;
                op_q     <= 1'b0;
                busy_q   <= 1'b1;
                status_q <= 1'b0;
            end
            if (run && Test) begin
                op_q <= !op_last;
                if (elem_end && !last_op_run) elem_q <= elem_q + 3'd1;
            end
            if ((state_q == ST_DONE) ||
                (((state_q == ST_RUN) || (state_q == ST_FLUSH)) && !Test))
                busy_q <= 1'b0;
            if (mismatch) status_q <= 1'b1;
        end
    end

    assign bist_busy        = busy_q;
    assign bist_status      = status_q;
    assign bist_check_valid = cv_q;

`ifdef MARCH_BIST_FAIL_LOG_EN
    logic [AWIDTH-1:0] cmp_addr_q, fail_addr_q;
    logic [7:0]        fail_count_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cmp_addr_q   <= '0;
            fail_addr_q  <= '0;
            fail_count_q <= '0;
        end else begin
            cmp_addr_q <= addr;
            if (start) begin
                fail_addr_q  <= '0;
                fail_count_q <= '0;
            end else if (mismatch) begin
                if (fail_count_q == 8'd0)   fail_addr_q  <= cmp_addr_q;
                if (fail_count_q != 8'd255) fail_count_q <= fail_count_q + 8'd1;
            end
        end
    end

    assign fail_addr  = fail_addr_q;
    assign fail_count = fail_count_q;
`else
    assign fail_addr  = '0;
    assign fail_count = '0;
`endif

endmodule

// File: tb/tb_march_bist_controller.sv
// Scoreboard bench for march_bist_controller: a string-driven March model
// predicts every memory op and the final verdict; a monitor checks both.
module tb_march_bist_controller;

    localparam int DW = 32, AW = 4, DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst, Test, algo_sel, bg_sel;
    logic          we, re, bist_busy, bist_status, bist_check_valid;
    logic [AW-1:0] wraddr, rdaddr, fail_addr;
    logic [DW-1:0] datain, rddata;
    logic [7:0]    fail_count;

    always #5 clk = ~clk;

    march_bist_controller #(.DWIDTH(DW), .AWIDTH(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .Test(Test), .algo_sel(algo_sel), .bg_sel(bg_sel),
        .we(we), .wraddr(wraddr), .datain(datain), .re(re), .rdaddr(rdaddr),
        .rddata(rddata), .bist_busy(bist_busy), .bist_status(bist_status),
        .bist_check_valid(bist_check_valid), .fail_addr(fail_addr),
        .fail_count(fail_count)
    );

    // Memory with per-address stuck-at masks applied on read.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] f_and [DEPTH];
    logic [DW-1:0] f_or [DEPTH];

    always @(posedge clk) begin
        if (we) mem[wraddr] <= datain;
        if (re) rddata <= (mem[rdaddr] & f_and[rdaddr]) | f_or[rdaddr];
    end

    typedef struct { bit rd; int addr; logic [DW-1:0] val; } op_t;
    typedef struct { bit status; int faddr; int fcount; int lat; } res_t;

    op_t  exp_ops[$];
    res_t exp_res[$];
    int   checks = 0, failures = 0;
    int   cyc = 0, first_cyc = 0;
    bit   armed = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expand the algorithm's element list into ops and play them against a
    // faulty memory to predict the verdict.
    task automatic model_run(input bit algo, input bit bg);
        string         els[$];
        logic [DW-1:0] b0, v, got;
        logic [DW-1:0] mm [DEPTH];
        int            nops, cnt, fa;
        res_t          r;
        nops = 0; cnt = 0; fa = 0;
        for (int i = 0; i < DW; i++) b0[i] = bg && (i % 2 == 0);
        if (algo) els = '{"Uw0", "Ur0w1", "Ur1w0", "Dr0w1", "Dr1w0", "Ur0"};
        else      els = '{"Uw0", "Ur0w1", "Dr1w0"};
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        foreach (els[e]) begin
            string s;
            s = els[e];
            for (int j = 0; j < DEPTH; j++) begin
                int a;
                a = (s[0] == "D") ? DEPTH - 1 - j : j;
                for (int k = 1; k < s.len(); k += 2) begin
                    op_t o;
                    v = (s[k+1] == "1") ? ~b0 : b0;
                    o.rd = (s[k] == "r"); o.addr = a; o.val = v;
                    if (o.rd) begin
                        got = (mm[a] & f_and[a]) | f_or[a];
                        if (got !== v) begin
                            if (cnt == 0) fa = a;
                            if (cnt < 255) cnt++;
                        end
                    end else begin
                        mm[a] = v;
                    end
                    exp_ops.push_back(o);
                    nops++;
                end
            end
        end
        r.status = (cnt != 0);
        r.lat    = nops + 2;
`ifdef MARCH_BIST_FAIL_LOG_EN
        r.faddr  = fa;
        r.fcount = cnt;
`else
        r.faddr  = 0;
        r.fcount = 0;
`endif
        exp_res.push_back(r);
    endtask

    always @(negedge clk) begin
        cyc++;
        if (we || re) begin
            op_t e;
            chk("we_re_exclusive", we & re, 0);
            if (armed) begin first_cyc = cyc; armed = 0; end
            if (exp_ops.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_op we=%0b re=%0b at t=%0t", we, re, $time);
            end else begin
                e = exp_ops.pop_front();
                chk("op_is_read", re, e.rd);
                chk("op_addr", re ? rdaddr : wraddr, e.addr);
                if (!e.rd) chk("op_wdata", datain, e.val);
            end
        end
        if (bist_check_valid) begin
            res_t r;
            if (exp_res.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_check_valid at t=%0t", $time);
            end else begin
                r = exp_res.pop_front();
                chk("done_status", bist_status, r.status);
                chk("done_fail_addr", fail_addr, r.faddr);
                chk("done_fail_count", fail_count, r.fcount);
                chk("done_latency", cyc - first_cyc, r.lat);
                chk("done_busy_low", bist_busy, 0);
            end
        end
    end

    task automatic clear_faults();
        for (int i = 0; i < DEPTH; i++) begin f_and[i] = '1; f_or[i] = '0; end
    endtask

    task automatic start_run(input bit algo, input bit bg);
        model_run(algo, bg);
        @(posedge clk); #1;
        armed = 1; algo_sel = algo; bg_sel = bg; Test = 1;
        @(posedge clk); #1;
        algo_sel = 1'($urandom); bg_sel = 1'($urandom);
    endtask

    task automatic run_full(input bit algo, input bit bg);
        int t;
        start_run(algo, bg);
        @(negedge clk);
        chk("busy_during_run", bist_busy, 1);
        t = 0;
        while (exp_res.size() != 0 && t < 3000) begin @(negedge clk); t++; end
        if (t >= 3000) begin
            checks++; failures++;
            $display("FAIL run_timeout pending=%0d", exp_res.size());
            exp_res.delete();
        end
        chk("ops_all_issued", exp_ops.size(), 0);
        exp_ops.delete();
        @(posedge clk); #1; Test = 0;
        repeat (3) @(posedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_we"}, we, 0);
        chk({tag, "_re"}, re, 0);
        chk({tag, "_busy"}, bist_busy, 0);
        chk({tag, "_status"}, bist_status, 0);
        chk({tag, "_cv"}, bist_check_valid, 0);
        chk({tag, "_addrs"}, {wraddr, rdaddr, fail_addr, fail_count}, 0);
        chk({tag, "_datain"}, datain, 0);
    endtask

    initial begin
        rst = 0; Test = 0; algo_sel = 0; bg_sel = 0;
        clear_faults();
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1; rst = 1;
        repeat (2) @(posedge clk);

        run_full(1'b0, 1'b0);                       // MATS+ solid
        run_full(1'b1, 1'b1);                       // March C- checkerboard

        f_and[3] = '0;                              // mem[3] reads as 0
        run_full(1'b1, 1'b0);
        clear_faults();

        f_or[15] = 32'h1;                           // bit 0 stuck-at-1
        run_full(1'b0, 1'b0);
        clear_faults();

        // Abort by dropping Test mid-run
        start_run(1'b1, 1'b0);
        repeat (38) @(posedge clk);
        #1; Test = 0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy", bist_busy, 0);
        exp_ops.delete(); exp_res.delete();
        repeat (200) @(negedge clk);
        run_full(1'b1, 1'b1);

        // Reset pulse mid-run on a failing run
        f_and[3] = '0;
        start_run(1'b1, 1'b0);
        repeat (78) @(posedge clk);
        #1; rst = 0; Test = 0;
        @(posedge clk); #1; rst = 1;
        exp_ops.delete(); exp_res.delete();
        @(negedge clk);
        check_idle_outputs("midrun_reset");
        repeat (20) @(negedge clk);
        chk("post_reset_idle", {we, re, bist_busy}, 0);
        clear_faults();
        run_full(1'b0, 1'b1);
        run_full(1'b0, 1'b1);

        // Randomized runs with an optional single stuck bit
        for (int n = 0; n < 8; n++) begin
            bit algo, bg;
            int a, b;
            algo = 1'($urandom); bg = 1'($urandom);
            clear_faults();
            if ($urandom_range(1, 0) == 1) begin
                a = $urandom_range(DEPTH - 1, 0);
                b = $urandom_range(DW - 1, 0);
                if ($urandom_range(1, 0) == 1) f_or[a][b] = 1'b1;
                else                           f_and[a][b] = 1'b0;
            end
            run_full(algo, bg);
        end
        clear_faults();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/march_bist_controller.md
Name: march_bist_controller

Overview:
- Parametrised successor to the single-algorithm BIST controller. It drives a synchronous single-port-per-direction memory model through a run-time-selectable March algorithm (MATS+ or March C-) with a selectable data background.
- Compares every read against its expected value and reports pass/fail, a done pulse and busy.
- Sits between the test-mode control and the memory model, in place of the earlier fixed controller.

Parameters:
- DWIDTH, 32, data word width (≥2, even).
- AWIDTH, 4, address width.
- DEPTH, 2**AWIDTH, number of words tested (1..2**AWIDTH). Addresses run 0..DEPTH-1.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-low.
- Test  in  1  test enable; run starts on 0→1 while IDLE; level must stay high during run.
- algo_sel  in  1  0 = MATS+, 1 = March C-; sampled at start.
- bg_sel  in  1  0 = solid (bg0 = all zeros), 1 = checkerboard (bg0 = alternating 0101…, LSB 1); sampled at start.
- we  out  1  memory write enable.
- wraddr  out  AWIDTH  write address.
- datain  out  DWIDTH  write data.
- re  out  1  memory read enable.
- rdaddr  out  AWIDTH  read address.
- rddata  in  DWIDTH  read data, valid the cycle after re.
- bist_busy  out  1  high while a run is in progress.
- bist_status  out  1  sticky fail, 0 = pass.
- bist_check_valid  out  1  one-cycle done pulse.
- fail_addr  out  AWIDTH  address of first failing read.
- fail_count  out  8  number of failing reads.

Behaviour:
- Reset (rst=0 at posedge): state IDLE; we, re, bist_busy, bist_status, bist_check_valid = 0; wraddr, rdaddr, datain, fail_addr, fail_count = 0; compare pipeline cleared. Reset mid-run aborts immediately; no check_valid pulse.
- Notation: bg1 = ~bg0; "0" in an element means bg0, "1" means bg1.
- MATS+ elements: ⇕(w0); ⇑(r0,w1); ⇓(r1,w0). Total 5*DEPTH ops.
- March C- elements: ⇕(w0); ⇑(r0,w1); ⇑(r1,w0); ⇓(r0,w1); ⇓(r1,w0); ⇕(r0). Total 10*DEPTH ops. ⇕ executes ascending.
- One op per cycle, no idle cycles between ops, elements or addresses.
- Read op: re=1, rdaddr=addr. Write op: we=1, wraddr=addr, datain=value. we and re are never both high.
- Ascending counter: 0→DEPTH-1. Descending: DEPTH-1→0. The element advances after the last op at the end address; no wrap-around beyond DEPTH-1.
- Compare pipeline: on each read, register expected data and address. Next cycle, compare rddata against expected. On mismatch, bist_status←1 (sticky until next start or reset).
- States:
  - IDLE: wait for Test 0→1. On start: sample algo_sel and bg_sel, clear bist_status and fail log, bist_busy←1, go to RUN.
  - RUN: issue ops. After the final op go to FLUSH.
  - FLUSH: one cycle; the last read is compared; go to DONE.
  - DONE: bist_check_valid=1 for exactly one cycle, bist_busy←0; go to HOLD.
  - HOLD: bist_status held; return to IDLE when Test=0.
- Latency: first op in the cycle after the start edge is seen. check_valid occurs ops+2 cycles after the first op (ops+1 for FLUSH and DONE).
- Test dropping to 0 during RUN or FLUSH: abort to IDLE, bist_busy←0, no check_valid, bist_status keeps its partial value.
- A mismatch detected in FLUSH is included in the status reported at DONE.
- DEPTH=1: all elements are valid single-address sweeps.

Optional Feature:
- Macro: MARCH_BIST_FAIL_LOG_EN.
- Defined:
  - fail_addr captures the address of the first mismatching read of the run.
  - fail_count increments per mismatch and saturates at 255.
  - Both are cleared at start.
- Not defined: fail_addr and fail_count are tied to 0; no logging flops.

Decomposition:
- Shared package march_bist_pkg holds:
  - state enum (IDLE, RUN, FLUSH, DONE, HOLD);
  - element op-code encoding (op count, r/w sequence, expected/write polarity, direction);
  - constant tables for the MATS+ (3 elements) and March C- (6 elements) sequences;
  - algo_sel encodings.
- One sub-module, march_bist_addr_gen: up/down address counter with load, step, and last-address flag.
- Background generation and compare stay in the top level.

Test Plan:
- MATS+, solid background, fault-free model, DEPTH=16: check_valid 82 cycles after the first op, bist_status=0, fail_count=0.
- March C-, checkerboard background, fault-free: check_valid after 162 cycles, status=0. Spot-check datain=32'h55555555 on the first w0 and 32'hAAAAAAAA on the ⇑(r0,w1) writes.
- March C- with mem[3] forced to 0 (solid background): status=1, fail_addr=3, fail_count=2 (r1 in elements 3 and 5).
- MATS+ with a bit-0 stuck-at-1 at address 15: status=1, fail_addr=15, fail_count=1.
- Test dropped at cycle 40 of a March C- run: busy→0 next cycle, no check_valid pulse. A subsequent start completes and passes.
- rst=0 for one cycle mid-run: all outputs 0 on the next cycle, state IDLE. Back-to-back runs with Test toggled pass twice.
